// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the instruction-fetch bus master.
//   - FSM state encoding for fetch_bus_if
//   - ENABLE_ / DISABLE_ levels for the active-low bus strobes
//   - default word-address and data widths
//   - NOP (all-zero) instruction word, also the rd_data reset/error value
package bus_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 30;
  localparam int unsigned DEFAULT_DATA_W = 32;

  // Active-low bus signalling levels
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Fetch FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: cycle counter for bus-access timeout detection.
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   clr_i  in  clear count to zero (takes priority over en_i)
//   en_i   in  count this cycle
//   tc_o   out terminal count: high on the Limit-th enabled cycle since clear
module bus_timeout_cnt #(
  parameter int unsigned Limit = 16  // must be >= 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // cnt_q holds the number of enabled cycles already seen, so the current
  // enabled cycle is the Limit-th one when cnt_q == Limit-1.
  assign tc_o = en_i && (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_bus_if.sv
// fetch_bus_if: instruction-fetch bus master. Takes a word-address read from
// the IF stage, requests the shared bus, runs one read cycle with the
// active-low as_/rdy_ handshake and returns the word with a one-cycle valid.
// Optional feature: define BUS_TIMEOUT_EN to abort accesses that see no rdy_
// within TIMEOUT_CYCLES ACCESS cycles (bus_err pulse, rd_data = 0).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req, cpu_addr       fetch request / word address (sampled in IDLE)
//   flush               cancel current or pending fetch
//   stall               pipeline stall; holds returned data (HOLD state)
//   busy                pipeline must stall
//   rd_data, data_valid fetched word (registered) and its one-cycle pulse
//   bus_err             timeout pulse (0 without BUS_TIMEOUT_EN)
//   bus_req_, bus_grnt_ arbiter request / grant, active-low
//   bus_addr, bus_as_   registered bus address and address strobe (active-low)
//   bus_rd_data         slave read data
//   bus_rdy_            slave ready, active-low
module fetch_bus_if
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
`ifdef BUS_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  input  logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              data_valid,
  output logic              bus_err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_as_q, bus_as_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              data_valid_q, data_valid_d;
  logic              discard_q, discard_d;
  logic              drop;

`ifdef BUS_TIMEOUT_EN
  logic cnt_clr, cnt_en, timeout;
  logic bus_err_q, bus_err_d;

  // Cleared on the REQ->ACCESS transition, counts ACCESS cycles without rdy_
  assign cnt_clr = (state_q == ST_REQ) && !flush && (bus_grnt_ == ENABLE_);
  assign cnt_en  = (state_q == ST_ACCESS) && (bus_rdy_ != ENABLE_);

  bus_timeout_cnt #(
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (timeout)
  );
`endif

  // A flush in the same cycle as rdy_ still drops the data.
  assign drop = discard_q | flush;

  always_comb begin
    state_d      = state_q;
    bus_addr_d   = bus_addr_q;
    bus_req_d    = bus_req_q;
    bus_as_d     = DISABLE_;
    rd_data_d    = rd_data_q;
    data_valid_d = 1'b0;
    discard_d    = discard_q;
`ifdef BUS_TIMEOUT_EN
    bus_err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req && !flush) begin
          bus_addr_d = cpu_addr;
          bus_req_d  = ENABLE_;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush) begin
          bus_req_d = DISABLE_;
          state_d   = ST_IDLE;
        end else if (bus_grnt_ == ENABLE_) begin
          bus_as_d = ENABLE_;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // The bus cycle is never aborted by flush; only its data is dropped.
        if (bus_rdy_ == ENABLE_) begin
          bus_req_d = DISABLE_;
          if (!drop) begin
            rd_data_d    = bus_rd_data;
            data_valid_d = 1'b1;
          end
          discard_d = 1'b0;
          state_d   = stall ? ST_HOLD : ST_IDLE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (timeout) begin
          bus_err_d = 1'b1;
          bus_req_d = DISABLE_;
          if (!drop) begin
            rd_data_d    = DATA_W'(NOP_INSTR);
            data_valid_d = 1'b1;
          end
          discard_d = 1'b0;
          state_d   = ST_IDLE;
        end
`endif
        else begin
          discard_d = drop;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bus_addr_q   <= '0;
      bus_req_q    <= DISABLE_;
      bus_as_q     <= DISABLE_;
      rd_data_q    <= DATA_W'(NOP_INSTR);
      data_valid_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_addr_q   <= bus_addr_d;
      bus_req_q    <= bus_req_d;
      bus_as_q     <= bus_as_d;
      rd_data_q    <= rd_data_d;
      data_valid_q <= data_valid_d;
      discard_q    <= discard_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    busy = 1'b1;
    if (reset) begin
      busy = 1'b0;
    end else if (state_q == ST_IDLE) begin
      busy = req & ~flush;
    end else if (state_q == ST_HOLD) begin
      busy = 1'b0;
    end
  end

  assign bus_addr   = bus_addr_q;
  assign bus_req_   = bus_req_q;
  assign bus_as_    = bus_as_q;
  assign rd_data    = rd_data_q;
  assign data_valid = data_valid_q;

endmodule

// File: doc/fetch_bus_if.md
# fetch_bus_if

Bus master for the instruction-fetch stage: accepts a word-address read request from the pipeline, requests the bus from the arbiter, runs one read cycle against the selected slave (ROM, SPM, etc.) using the active-low `as_` / `rdy_` handshake, and returns the read word with a one-cycle valid pulse. The block sits between the IF pipeline register and the shared bus. It drives `busy` so the pipeline stalls for the full bus access.

## Interface
- `ADDR_W`, 30, word-address width on CPU and bus side
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 16, maximum `ACCESS` cycles before bus error; used only with `BUS_TIMEOUT_EN`

- `clk` in 1: single clock; all state changes on its rising edge
- `reset` in 1: synchronous, active-high
- `req` in 1: fetch request, sampled in `IDLE`
- `cpu_addr` in ADDR_W: fetch word address
- `flush` in 1: cancel the current or pending fetch
- `stall` in 1: pipeline stall; holds returned data
- `busy` out 1: pipeline must stall
- `rd_data` out DATA_W: fetched word, registered
- `data_valid` out 1: one-cycle pulse when `rd_data` is updated
- `bus_err` out 1: one-cycle pulse on timeout; constant 0 without the macro
- `bus_req_` out 1: arbiter request, active-low
- `bus_grnt_` in 1: arbiter grant, active-low
- `bus_addr` out ADDR_W: bus address, registered
- `bus_as_` out 1: address strobe, active-low, registered
- `bus_rd_data` in DATA_W: slave read data
- `bus_rdy_` in 1: slave ready, active-low

## Operation
- States are `IDLE`, `REQ`, `ACCESS` and `HOLD`.
- **IDLE**
  - If `req & ~flush`: latch `cpu_addr` into `bus_addr`, drive `bus_req_`=0, go to `REQ`.
  - `busy` = `req & ~flush` (combinational).
- **REQ**
  - `busy`=1.
  - If `flush`: drive `bus_req_`=1, go to `IDLE`; no strobe is issued.
  - Else if `bus_grnt_`=0: drive `bus_as_`=0 for exactly one cycle, go to `ACCESS`.
- **ACCESS**
  - `busy`=1.
  - `flush` in this state sets the `discard` flag. The bus cycle is never aborted.
  - On `bus_rdy_`=0:
    - Release `bus_req_`.
    - If not `discard`: register `bus_rd_data` into `rd_data` and pulse `data_valid`.
    - Clear `discard`.
    - Next state is `HOLD` if `stall`, else `IDLE`.
- **HOLD**
  - `busy`=0; `rd_data` is held.
  - Leave to `IDLE` when `stall`=0.
  - `req` is ignored while in `HOLD`.
- Read-only master: no write path, no byte enables.
- Simultaneous `flush` and `bus_rdy_` in `ACCESS`: data is discarded.
- `flush` and `req` together in `IDLE`: no request is issued.

## Timing
- Reset values (outputs):
  - `bus_req_`=1, `bus_as_`=1, `bus_addr`=0, `rd_data`=0.
  - `data_valid`=0, `bus_err`=0.
  - `busy` is forced to 0 while `reset`=1.
- Reset values (internal): state=`IDLE`, `discard`=0, timeout counter=0.
- Reset mid-operation: `bus_req_` and `bus_as_` return to 1 on the next edge. An outstanding slave access is abandoned.
- Latency with immediate grant and a 1-wait slave such as ROM (`rdy_` registered one cycle after `as_`):
  - Cycle 0: `req`.
  - Cycle 1: `REQ`.
  - Cycle 2: `bus_as_`=0.
  - Cycle 3: `bus_rdy_`=0.
  - Cycle 4: `rd_data` valid, `data_valid`=1, `busy`=0.
- `bus_as_` is low for exactly one cycle per transaction. `bus_addr` is stable from `REQ` until return to `IDLE`.
- Back-to-back fetch: a new `req` in cycle 4 (`IDLE`) starts the next transaction. Minimum 4 cycles per fetch.

## Configuration
- Macro: `BUS_TIMEOUT_EN`.
- Defined:
  - The counter is cleared on entry to `ACCESS` and increments each `ACCESS` cycle without `rdy_`.
  - On reaching `TIMEOUT_CYCLES`:
    - Pulse `bus_err`.
    - Load `rd_data`=0 and pulse `data_valid` (suppressed if `discard`).
    - Release the bus and go to `IDLE`.
  - `rdy_` arriving in the same cycle as the timeout wins, and no error is raised.
- Undefined: `ACCESS` waits indefinitely, `bus_err` is tied to 0, and no counter logic exists.

## Structure
- Shared package `bus_pkg`:
  - State encoding.
  - `ENABLE_` / `DISABLE_` active-low constants.
  - `ADDR_W` / `DATA_W` defaults.
  - NOP/zero instruction constant.
- Sub-module `bus_timeout_cnt` (clear, enable, terminal-count pulse), instantiated only under `BUS_TIMEOUT_EN`.

## Test plan
- Reset then `req` with `cpu_addr`=0x00000010, grant immediate, slave returns 0xDEADBEEF one cycle after `as_` -> `bus_as_` low in cycle 2 only; `rd_data`=0xDEADBEEF with `data_valid` in cycle 4; `busy` 1 in cycles 0-3.
- Grant delayed 3 cycles -> `bus_as_` not asserted until the cycle after grant; `bus_addr` holds 0x10 throughout.
- `flush` in `REQ` -> `bus_req_` returns to 1 next cycle, no `as_` pulse. `flush` in `ACCESS` -> cycle completes, `data_valid` stays 0, `rd_data` unchanged.
- `stall`=1 when `rdy_` arrives -> `HOLD`; `req` ignored and `rd_data` stable for 5 cycles; back to `IDLE` after `stall` drops.
- With `BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, slave never asserts `rdy_` -> `bus_err` pulse after 16 `ACCESS` cycles, `rd_data`=0, bus released. Without the macro -> `busy` stays 1 indefinitely.
- Assert `reset` during `ACCESS` -> all outputs at reset values on the next edge; a following `req` completes normally.
